aes_mix_columns_seq: RTL

- Iterative MixColumns round stage for the AES datapath.
- Accepts a full 128-bit state and processes one 32-bit column per clock through a single column multiplier (the a/b/c column-byte path), using 4 column passes.
- Returns the mixed state through a valid/ready handshake.
- Sits between ShiftRows (upstream) and AddRoundKey (downstream) in the round loop; trades throughput for one shared column multiplier.

---
 rtl/aes_mix_pkg.sv | 21 ++
 rtl/aes_mix_single_column.sv | 71 +++++++
 rtl/aes_mix_columns_seq.sv | 122 ++++++++++++
 3 files changed

// File: rtl/aes_mix_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES MixColumns stage.
package aes_mix_pkg;

  // Reduction constant of the AES field polynomial x^8 + x^4 + x^3 + x + 1
  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mix_state_t;

  typedef logic [7:0]  aes_byte_t;
  typedef logic [31:0] aes_col_t;

  // Multiply by x (i.e. by 2) in GF(2^8)
  function automatic aes_byte_t xtime(input aes_byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_mix_single_column.sv
// Combinational MixColumns on one 32-bit column (byte a0 in the top byte).
// Inverse coefficients are only built when AES_MIX_INV_EN is defined.
module aes_mix_single_column
  import aes_mix_pkg::*;
(
  input  aes_col_t col_i,
  input  logic     inv_i,
  output aes_col_t col_o
);

  aes_byte_t a0, a1, a2, a3;
  aes_byte_t x0, x1, x2, x3;
  aes_col_t  fwdCol;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);

  // Forward matrix rows {2,3,1,1} rotated per output byte; 3a = 2a ^ a
  always_comb begin
    fwdCol[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
    fwdCol[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
    fwdCol[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
    fwdCol[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;
  end

`ifdef AES_MIX_INV_EN
  aes_byte_t q0, q1, q2, q3;
  aes_byte_t e0, e1, e2, e3;
  aes_byte_t m9[4], mb[4], md[4], me[4];
  aes_col_t  invCol;

  assign q0 = xtime(x0);
  assign q1 = xtime(x1);
  assign q2 = xtime(x2);
  assign q3 = xtime(x3);
  assign e0 = xtime(q0);
  assign e1 = xtime(q1);
  assign e2 = xtime(q2);
  assign e3 = xtime(q3);

  // Build 9,b,d,e multiples from the 2x/4x/8x chain of each input byte
  always_comb begin
    m9[0] = e0 ^ a0;       m9[1] = e1 ^ a1;       m9[2] = e2 ^ a2;       m9[3] = e3 ^ a3;
    mb[0] = e0 ^ x0 ^ a0;  mb[1] = e1 ^ x1 ^ a1;  mb[2] = e2 ^ x2 ^ a2;  mb[3] = e3 ^ x3 ^ a3;
    md[0] = e0 ^ q0 ^ a0;  md[1] = e1 ^ q1 ^ a1;  md[2] = e2 ^ q2 ^ a2;  md[3] = e3 ^ q3 ^ a3;
    me[0] = e0 ^ q0 ^ x0;  me[1] = e1 ^ q1 ^ x1;  me[2] = e2 ^ q2 ^ x2;  me[3] = e3 ^ q3 ^ x3;
  end

  // Inverse matrix rows {0e,0b,0d,09} rotated per output byte
  always_comb begin
    invCol[31:24] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    invCol[23:16] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    invCol[15:8]  = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    invCol[7:0]   = mb[0] ^ md[1] ^ m9[2] ^ me[3];
  end

  assign col_o = inv_i ? invCol : fwdCol;
`else
  logic unusedInv;
  assign unusedInv = inv_i;
  assign col_o     = fwdCol;
`endif

endmodule

// File: rtl/aes_mix_columns_seq.sv
// Iterative AES MixColumns: one column per clock through a shared column
// multiplier, four passes per state, valid/ready on both sides.
// Optional feature macro: AES_MIX_INV_EN (inverse MixColumns via in_inv).
module aes_mix_columns_seq
  import aes_mix_pkg::*;
#(
  parameter int NCOL  = 4,
  parameter int COL_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NCOL*COL_W-1:0]   in_state,
  input  logic                    in_inv,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NCOL*COL_W-1:0]   out_state,
  output logic                    busy
);

  if (NCOL != 4 || COL_W != 32) begin : g_bad_cfg
    $error("aes_mix_columns_seq: only NCOL=4 and COL_W=32 are legal");
  end

  mix_state_t                fsm_q, fsm_d;
  logic [1:0]                col_cnt_q, col_cnt_d;
  logic [NCOL*COL_W-1:0]     state_q, state_d;
  logic                      inv_q;
  aes_col_t                  colIn, colOut;

  // Pick the column currently being mixed out of the held state
  always_comb begin
    colIn = state_q[127:96];
    case (col_cnt_q)
      2'd0: colIn = state_q[127:96];
      2'd1: colIn = state_q[95:64];
      2'd2: colIn = state_q[63:32];
      2'd3: colIn = state_q[31:0];
      default: colIn = state_q[127:96];
    endcase
  end

  aes_mix_single_column u_column (
    .col_i (colIn),
    .inv_i (inv_q),
    .col_o (colOut)
  );

  // State register: FSM, column counter and the working state
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= IDLE;
      col_cnt_q <= 2'd0;
      state_q   <= '0;
    end else begin
      fsm_q     <= fsm_d;
      col_cnt_q <= col_cnt_d;
      state_q   <= state_d;
    end
  end

`ifdef AES_MIX_INV_EN
  // Direction is latched with the state so a changing in_inv cannot disturb a pass
  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q <= 1'b0;
    end else if (fsm_q == IDLE && in_valid) begin
      inv_q <= in_inv;
    end
  end
`else
  logic unusedInInv;
  assign unusedInInv = in_inv;
  assign inv_q       = 1'b0;
`endif

  // Next state: load on accept, replace one column per BUSY cycle, release on handshake
  always_comb begin
    fsm_d     = fsm_q;
    col_cnt_d = col_cnt_q;
    state_d   = state_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d   = in_state;
          col_cnt_d = 2'd0;
          fsm_d     = BUSY;
        end
      end
      BUSY: begin
        case (col_cnt_q)
          2'd0: state_d[127:96] = colOut;
          2'd1: state_d[95:64]  = colOut;
          2'd2: state_d[63:32]  = colOut;
          2'd3: state_d[31:0]   = colOut;
          default: state_d = state_q;
        endcase
        col_cnt_d = col_cnt_q + 2'd1;
        if (col_cnt_q == 2'd3) begin
          fsm_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Outputs decoded purely from the FSM state
  always_comb begin
    in_ready  = (fsm_q == IDLE);
    out_valid = (fsm_q == DONE);
    busy      = (fsm_q == BUSY) || (fsm_q == DONE);
  end

  assign out_state = state_q;

endmodule
